iq_demod_integrator: RTL and testbench
======================================

Name: iq_demod_integrator

Overview:
- Readout-side counterpart of the NCO phase accumulator.
- Consumes the truncated NCO phase word plus ADC samples, and mixes each sample with cos/sin of that phase.
- Integrates the products over a programmable window and delivers one I/Q pair per window through a valid/ready handshake.
- Sits between the NCO/ADC front end and the qubit state discrimination logic.

Parameters:
- PHASE_WIDTH, 10: width of phase_in; matches the NCO OUTPUT_WIDTH.
- SAMPLE_WIDTH, 8: signed ADC sample width.
- AMP_WIDTH, 8: signed cos/sin amplitude width; peak amplitude is 2^(AMP_WIDTH-1)-1.
- LEN_WIDTH, 10: integration length register width, in samples.
- ACC_WIDTH, 24: signed accumulator and output width.

Ports:
- clk, in, 1: clock.
- rst, in, 1: asynchronous, active-high reset.
- len_wr_en, in, 1: load len_in into the length register.
- len_in, in, LEN_WIDTH: integration length in samples.
- start, in, 1: begin an integration window.
- sample_valid, in, 1: sample_in and phase_in are valid this cycle.
- sample_in, in, SAMPLE_WIDTH: signed ADC sample.
- phase_in, in, PHASE_WIDTH: NCO phase MSBs.
- busy, out, 1: high in every state except IDLE.
- iq_valid, out, 1: I/Q result valid.
- iq_ready, in, 1: consumer accepts the result.
- i_out, out, ACC_WIDTH: signed I sum.
- q_out, out, ACC_WIDTH: signed Q sum.

Behaviour:
- Reset values: all outputs 0, length register 0, FSM in IDLE, accumulators 0, pipeline valids 0. Reset asserted in any state, including mid-window or while HOLD is waiting, aborts immediately; no result is emitted.
- len_wr_en takes effect in any state. A running window uses the length latched at start.
- LUT:
  - cos(p) = round(A*cos(2*pi*p/2^PHASE_WIDTH)); sin is defined likewise; A = 2^(AMP_WIDTH-1)-1.
  - Built as a quarter-wave table indexed by the low PHASE_WIDTH-2 bits; the 2 MSBs select quadrant mirroring and negation.
- Pipeline, advancing only on accepted samples:
  - S1: registered LUT output plus delayed sample.
  - S2: registered signed products, width SAMPLE_WIDTH+AMP_WIDTH.
  - S3: accumulate with sign extension. acc_i += s*cos; acc_q -= s*sin.
  - Accumulators wrap in two's complement; there is no saturation.
- FSM states:
  - IDLE:
    - Condition: start=1 and latched length != 0.
    - Action: clear accumulators, load cnt with the latched length, go to INTEG.
    - start with length 0 is ignored and the FSM stays in IDLE.
    - sample_valid is ignored in IDLE.
  - INTEG:
    - Each sample_valid=1 cycle feeds the pipeline and decrements cnt.
    - On the sample that brings cnt to 0, go to DRAIN.
    - Gaps in sample_valid are allowed.
  - DRAIN:
    - Wait 2 cycles for S2/S3 to empty, then latch i_out/q_out, assert iq_valid, go to HOLD.
    - iq_valid rises exactly 3 cycles after the clock edge that accepts the last sample.
    - Samples arriving in DRAIN are ignored.
  - HOLD:
    - iq_valid, i_out and q_out stay stable until iq_valid&iq_ready.
    - On the handshake: drop iq_valid and go to IDLE.
    - start is ignored in HOLD, including in the handshake cycle.
    - i_out/q_out keep their last values after the handshake.
- start while busy is always ignored.

Optional Feature:
- Macro: IQ_DEMOD_THRESHOLD_EN.
- When defined:
  - Adds port thr_in (in, ACC_WIDTH, signed) and output state_out (out, 1).
  - state_out = (i_out > thr_in), registered at the same edge that sets iq_valid and held through HOLD.
  - state_out resets to 0.
- When undefined: neither port exists and there is no comparator logic.

Decomposition:
- Shared package iq_demod_pkg holds:
  - default width constants;
  - the FSM state enum (IDLE, INTEG, DRAIN, HOLD);
  - the LUT amplitude constant A and the quarter-table depth.
- Sub-module sincos_lut (PHASE_WIDTH, AMP_WIDTH):
  - registered quarter-wave cos/sin lookup with quadrant folding;
  - one S1 pipeline stage;
  - reusable by the drive-side waveform path.

Test Plan:
- Length 4, phase_in=0, sample_in=+100 for 4 cycles, iq_ready=1 -> iq_valid 3 cycles after the last sample, I=50800, Q=0, busy drops the cycle after the handshake.
- Length 4, phase_in=256 (90 deg), sample_in=+100 -> I=0, Q=-50800. Then phase_in=512, sample=-50 -> I=+25400, Q=0.
- Length 3 with sample_valid gaps (1,0,0,1,0,1), iq_ready held low 5 cycles, start pulsed during HOLD -> outputs stable throughout, exactly one result, second start ignored, FSM returns to IDLE.
- Length register 0, start pulsed -> busy stays 0, no iq_valid. Then len_wr_en with 1 and start, 1 sample of +1 at phase 0 -> I=127, Q=0.
- rst asserted asynchronously mid-INTEG, then mid-HOLD -> all outputs 0 immediately, no iq_valid. A fresh window afterwards gives results matching the golden model.
- With IQ_DEMOD_THRESHOLD_EN and thr_in=50000: first scenario -> state_out=1; thr_in=60000 -> state_out=0.

Source files
------------

// File: rtl/iq_demod_pkg.sv
// Shared constants, FSM state type and quarter-wave sine helper for the I/Q demodulator.
package iq_demod_pkg;

    localparam int PHASE_WIDTH_DEF  = 10;
    localparam int SAMPLE_WIDTH_DEF = 8;
    localparam int AMP_WIDTH_DEF    = 8;
    localparam int LEN_WIDTH_DEF    = 10;
    localparam int ACC_WIDTH_DEF    = 24;

    localparam int LUT_AMP       = 2**(AMP_WIDTH_DEF-1) - 1;
    localparam int QUARTER_DEPTH = 2**(PHASE_WIDTH_DEF-2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int     FRAC  = 28;
    localparam longint PI_FX = 64'sd843314857;  // round(pi * 2^28)

    // round(amp * sin(pi/2 * k/depth)) by fixed-point Taylor series; only ever
    // called with constant arguments, so it folds to table contents.
    function automatic int quarter_sin(input int k, input int depth, input int amp);
        longint x, x2, term, sum;
        x    = (longint'(k) * PI_FX) / longint'(2 * depth);
        x2   = (x * x) >>> FRAC;
        term = x;
        sum  = x;
        for (int n = 1; n <= 7; n++) begin
            term = -((term * x2) >>> FRAC) / longint'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return int'((sum * longint'(amp) + (64'sd1 <<< (FRAC - 1))) >>> FRAC);
    endfunction

endpackage

// File: rtl/sincos_lut.sv
// Registered cos/sin lookup from a quarter-wave table with quadrant folding (one pipeline stage).
module sincos_lut
    import iq_demod_pkg::*;
#(
    parameter int PHASE_WIDTH = PHASE_WIDTH_DEF,
    parameter int AMP_WIDTH   = AMP_WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic [PHASE_WIDTH-1:0]      phase,
    output logic signed [AMP_WIDTH-1:0] cos_out,
    output logic signed [AMP_WIDTH-1:0] sin_out
);

    localparam int QDEPTH = 2**(PHASE_WIDTH-2);
    localparam int AMP    = 2**(AMP_WIDTH-1) - 1;
    localparam logic [PHASE_WIDTH-2:0] QD_IDX = (PHASE_WIDTH-1)'(QDEPTH);

    // NOTE: the table is constant wiring, not storage, so it needs no reset.
    logic signed [AMP_WIDTH-1:0] rom [QDEPTH+1];
    for (genvar g = 0; g <= QDEPTH; g++) begin : g_rom
        assign rom[g] = AMP_WIDTH'(quarter_sin(g, QDEPTH, AMP));
    end

    logic [1:0]                  quad;
    logic [PHASE_WIDTH-2:0]      k_dir;
    logic [PHASE_WIDTH-2:0]      k_mir;
    logic signed [AMP_WIDTH-1:0] direct;
    logic signed [AMP_WIDTH-1:0] mirror;
    logic signed [AMP_WIDTH-1:0] sin_mag;
    logic signed [AMP_WIDTH-1:0] cos_mag;

    assign quad    = phase[PHASE_WIDTH-1:PHASE_WIDTH-2];
    assign k_dir   = {1'b0, phase[PHASE_WIDTH-3:0]};
    assign k_mir   = QD_IDX - k_dir;
    assign direct  = rom[k_dir];
    assign mirror  = rom[k_mir];
    // Odd quadrants swap the roles of the direct and mirrored reads.
    assign sin_mag = quad[0] ? mirror : direct;
    assign cos_mag = quad[0] ? direct : mirror;

    // NOTE: registers are updated with <= so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos_out <= '0;
            sin_out <= '0;
        end else if (en) begin
            sin_out <= quad[1] ? -sin_mag : sin_mag;
            cos_out <= (quad[0] ^ quad[1]) ? -cos_mag : cos_mag;
        end
    end

endmodule

// File: rtl/iq_demod_integrator.sv
// I/Q demodulating integrator: mixes ADC samples with cos/sin of the NCO phase and sums over a window.
// Optional threshold discriminator output enabled by defining IQ_DEMOD_THRESHOLD_EN.
module iq_demod_integrator
    import iq_demod_pkg::*;
#(
    parameter int PHASE_WIDTH  = PHASE_WIDTH_DEF,
    parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEF,
    parameter int AMP_WIDTH    = AMP_WIDTH_DEF,
    parameter int LEN_WIDTH    = LEN_WIDTH_DEF,
    parameter int ACC_WIDTH    = ACC_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           len_wr_en,
    input  logic [LEN_WIDTH-1:0]           len_in,
    input  logic                           start,
    input  logic                           sample_valid,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic [PHASE_WIDTH-1:0]         phase_in,
    output logic                           busy,
    output logic                           iq_valid,
    input  logic                           iq_ready,
    output logic signed [ACC_WIDTH-1:0]    i_out,
    output logic signed [ACC_WIDTH-1:0]    q_out
`ifdef IQ_DEMOD_THRESHOLD_EN
    ,
    input  logic signed [ACC_WIDTH-1:0]    thr_in,
    output logic                           state_out
`endif
);

    localparam int PROD_WIDTH = SAMPLE_WIDTH + AMP_WIDTH;

    state_e                          state;
    logic [LEN_WIDTH-1:0]            len_reg;
    logic [LEN_WIDTH-1:0]            cnt;
    logic [1:0]                      drain_cnt;
    logic                            accept;
    logic                            launch;
    logic                            s1_valid;
    logic                            s2_valid;
    logic signed [SAMPLE_WIDTH-1:0]  s1_sample;
    logic signed [AMP_WIDTH-1:0]     s1_cos;
    logic signed [AMP_WIDTH-1:0]     s1_sin;
    logic signed [PROD_WIDTH-1:0]    s2_prod_i;
    logic signed [PROD_WIDTH-1:0]    s2_prod_q;
    logic signed [ACC_WIDTH-1:0]     acc_i;
    logic signed [ACC_WIDTH-1:0]     acc_q;

    assign accept = (state == INTEG) && sample_valid;
    assign launch = (state == IDLE) && start && (len_reg != '0);
    assign busy   = (state != IDLE);

    sincos_lut #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .AMP_WIDTH   (AMP_WIDTH)
    ) u_lut (
        .clk     (clk),
        .rst     (rst),
        .en      (accept),
        .phase   (phase_in),
        .cos_out (s1_cos),
        .sin_out (s1_sin)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_reg <= '0;
        end else if (len_wr_en) begin
            len_reg <= len_in;
        end
    end

    // Valids flow every cycle; data registers only load behind a valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_sample <= '0;
            s2_prod_i <= '0;
            s2_prod_q <= '0;
            acc_i     <= '0;
            acc_q     <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (accept) begin
                s1_sample <= sample_in;
            end
            if (s1_valid) begin
                s2_prod_i <= s1_sample * s1_cos;
                s2_prod_q <= s1_sample * s1_sin;
            end
            if (launch) begin
                acc_i <= '0;
                acc_q <= '0;
            end else if (s2_valid) begin
                acc_i <= acc_i + ACC_WIDTH'(s2_prod_i);
                acc_q <= acc_q - ACC_WIDTH'(s2_prod_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            drain_cnt <= '0;
            iq_valid  <= 1'b0;
            i_out     <= '0;
            q_out     <= '0;
`ifdef IQ_DEMOD_THRESHOLD_EN
            state_out <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        cnt   <= len_reg;
                        state <= INTEG;
                    end
                end
                INTEG: begin
                    if (sample_valid) begin
                        cnt <= cnt - LEN_WIDTH'(1);
                        if (cnt == LEN_WIDTH'(1)) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Two cycles let the last product pass S2 and land in S3.
                    if (drain_cnt == 2'd2) begin
                        i_out    <= acc_i;
                        q_out    <= acc_q;
                        iq_valid <= 1'b1;
`ifdef IQ_DEMOD_THRESHOLD_EN
                        state_out <= (acc_i > thr_in);
`endif
                        state    <= HOLD;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                HOLD: begin
                    if (iq_ready) begin
                        iq_valid <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_demod_integrator.sv
// Directed self-checking bench for iq_demod_integrator; threshold scenario runs when IQ_DEMOD_THRESHOLD_EN is defined.
module tb_iq_demod_integrator;

    localparam int PW  = 10;
    localparam int SW  = 8;
    localparam int AW  = 8;
    localparam int LW  = 10;
    localparam int ACW = 24;

    logic                  clk;
    logic                  rst;
    logic                  len_wr_en;
    logic [LW-1:0]         len_in;
    logic                  start;
    logic                  sample_valid;
    logic signed [SW-1:0]  sample_in;
    logic [PW-1:0]         phase_in;
    logic                  busy;
    logic                  iq_valid;
    logic                  iq_ready;
    logic signed [ACW-1:0] i_out;
    logic signed [ACW-1:0] q_out;
`ifdef IQ_DEMOD_THRESHOLD_EN
    logic signed [ACW-1:0] thr_in;
    logic                  state_out;
`endif

    int checks;
    int errors;

    iq_demod_integrator #(
        .PHASE_WIDTH  (PW),
        .SAMPLE_WIDTH (SW),
        .AMP_WIDTH    (AW),
        .LEN_WIDTH    (LW),
        .ACC_WIDTH    (ACW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .len_wr_en    (len_wr_en),
        .len_in       (len_in),
        .start        (start),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .phase_in     (phase_in),
        .busy         (busy),
        .iq_valid     (iq_valid),
        .iq_ready     (iq_ready),
        .i_out        (i_out),
        .q_out        (q_out)
`ifdef IQ_DEMOD_THRESHOLD_EN
        ,
        .thr_in       (thr_in),
        .state_out    (state_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic idle_inputs();
        len_wr_en    = 1'b0;
        len_in       = '0;
        start        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        phase_in     = '0;
    endtask

    task automatic write_len(input int len);
        @(negedge clk);
        len_wr_en = 1'b1;
        len_in    = LW'(len);
        @(negedge clk);
        len_wr_en = 1'b0;
    endtask

    task automatic feed(input logic v, input logic signed [SW-1:0] s, input logic [PW-1:0] p);
        @(negedge clk);
        start        = 1'b0;
        len_wr_en    = 1'b0;
        sample_valid = v;
        sample_in    = s;
        phase_in     = p;
    endtask

    task automatic run_window(input int slots, input logic [15:0] mask,
                              input logic signed [SW-1:0] s, input logic [PW-1:0] p);
        @(negedge clk);
        start = 1'b1;
        for (int i = 0; i < slots; i++) feed(mask[i], s, p);
    endtask

    // lat counts clock edges after the one that accepted the last sample.
    task automatic wait_result(input logic junk, output int lat);
        @(negedge clk);
        sample_valid = junk;
        sample_in    = 8'sh80;
        phase_in     = 10'd100;
        lat = 0;
        while (!iq_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        checks++; if (iq_valid !== 1'b0) begin errors++; $display("FAIL reset_iq_valid got %0b exp 0", iq_valid); end
        checks++; if (i_out !== 0) begin errors++; $display("FAIL reset_i_out got %0d exp 0", i_out); end
        checks++; if (q_out !== 0) begin errors++; $display("FAIL reset_q_out got %0d exp 0", q_out); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        iq_ready = 1'b1;
        write_len(4);
        run_window(4, 16'hF, 8'sd100, 10'd0);
        wait_result(1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency got %0d exp 3", lat); end
        checks++; if (i_out !== 50800) begin errors++; $display("FAIL basic_i got %0d exp 50800", i_out); end
        checks++; if (q_out !== 0) begin errors++; $display("FAIL basic_q got %0d exp 0", q_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_hold got %0b exp 1", busy); end
        @(negedge clk);
        checks++; if (iq_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %0b exp 0", iq_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_drop got %0b exp 0", busy); end
    endtask

    task automatic test_quadrants();
        int lat;
        iq_ready = 1'b1;
        run_window(4, 16'hF, 8'sd100, 10'd256);
        wait_result(1'b0, lat);
        checks++; if (i_out !== 0) begin errors++; $display("FAIL quad90_i got %0d exp 0", i_out); end
        checks++; if (q_out !== -50800) begin errors++; $display("FAIL quad90_q got %0d exp -50800", q_out); end
        @(negedge clk);
        // Junk samples during DRAIN must not reach the sums.
        run_window(4, 16'hF, -8'sd50, 10'd512);
        wait_result(1'b1, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL quad180_latency got %0d exp 3", lat); end
        checks++; if (i_out !== 25400) begin errors++; $display("FAIL quad180_i got %0d exp 25400", i_out); end
        checks++; if (q_out !== 0) begin errors++; $display("FAIL quad180_q got %0d exp 0", q_out); end
        @(negedge clk);
    endtask

    task automatic test_gaps_hold();
        int   lat;
        logic bad;
        iq_ready = 1'b0;
        write_len(3);
        // Start latches length 3 while the register is rewritten to 1.
        @(negedge clk);
        start     = 1'b1;
        len_wr_en = 1'b1;
        len_in    = 10'd1;
        for (int i = 0; i < 6; i++) feed(6'b101001 >> i, 8'sd10, 10'd768);
        wait_result(1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL gaps_latency got %0d exp 3", lat); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            start = (c == 2);
            checks++;
            if (iq_valid !== 1'b1 || i_out !== 0 || q_out !== 3810) begin
                errors++;
                $display("FAIL hold_stable cycle %0d got valid=%0b i=%0d q=%0d exp valid=1 i=0 q=3810",
                         c, iq_valid, i_out, q_out);
            end
        end
        @(negedge clk);
        iq_ready = 1'b1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        iq_ready = 1'b0;
        checks++; if (iq_valid !== 1'b0) begin errors++; $display("FAIL gaps_valid_drop got %0b exp 0", iq_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gaps_start_in_handshake got busy=%0b exp 0", busy); end
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (iq_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL gaps_single_result got extra activity exp none"); end
        checks++; if (i_out !== 0 || q_out !== 3810) begin errors++; $display("FAIL gaps_keep_outputs got i=%0d q=%0d exp i=0 q=3810", i_out, q_out); end
    endtask

    task automatic test_len_zero();
        int   lat;
        logic bad;
        iq_ready = 1'b1;
        write_len(0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (busy !== 1'b0 || iq_valid !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL len0_ignored got busy/valid activity exp none"); end
        write_len(1);
        run_window(1, 16'h1, 8'sd1, 10'd0);
        wait_result(1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL len1_latency got %0d exp 3", lat); end
        checks++; if (i_out !== 127 || q_out !== 0) begin errors++; $display("FAIL len1_iq got i=%0d q=%0d exp i=127 q=0", i_out, q_out); end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int   lat;
        logic bad;
        iq_ready = 1'b0;
        write_len(4);
        run_window(2, 16'h3, 8'sd20, 10'd0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || iq_valid !== 1'b0 || i_out !== 0 || q_out !== 0) begin
            errors++;
            $display("FAIL rst_integ got busy=%0b valid=%0b i=%0d q=%0d exp all 0", busy, iq_valid, i_out, q_out);
        end
        @(negedge clk);
        rst          = 1'b0;
        sample_valid = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (iq_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++; if (bad !== 1'b0) begin errors++; $display("FAIL rst_integ_no_result got activity exp none"); end

        write_len(2);
        run_window(2, 16'h3, 8'sd5, 10'd0);
        wait_result(1'b0, lat);
        checks++; if (iq_valid !== 1'b1 || i_out !== 1270) begin errors++; $display("FAIL pre_hold got valid=%0b i=%0d exp valid=1 i=1270", iq_valid, i_out); end
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || iq_valid !== 1'b0 || i_out !== 0 || q_out !== 0) begin
            errors++;
            $display("FAIL rst_hold got busy=%0b valid=%0b i=%0d q=%0d exp all 0", busy, iq_valid, i_out, q_out);
        end
        @(negedge clk);
        rst      = 1'b0;
        iq_ready = 1'b1;
        write_len(2);
        run_window(2, 16'h3, 8'sd7, 10'd512);
        wait_result(1'b0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL fresh_latency got %0d exp 3", lat); end
        checks++; if (i_out !== -1778 || q_out !== 0) begin errors++; $display("FAIL fresh_iq got i=%0d q=%0d exp i=-1778 q=0", i_out, q_out); end
        @(negedge clk);
        checks++; if (iq_valid !== 1'b0) begin errors++; $display("FAIL fresh_handshake got %0b exp 0", iq_valid); end
    endtask

`ifdef IQ_DEMOD_THRESHOLD_EN
    task automatic test_threshold();
        int lat;
        iq_ready = 1'b1;
        thr_in   = 24'sd50000;
        write_len(4);
        run_window(4, 16'hF, 8'sd100, 10'd0);
        wait_result(1'b0, lat);
        checks++; if (state_out !== 1'b1) begin errors++; $display("FAIL thr_50000 got %0b exp 1", state_out); end
        @(negedge clk);
        thr_in = 24'sd60000;
        run_window(4, 16'hF, 8'sd100, 10'd0);
        wait_result(1'b0, lat);
        checks++; if (state_out !== 1'b0) begin errors++; $display("FAIL thr_60000 got %0b exp 0", state_out); end
        @(negedge clk);
    endtask
`endif

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        iq_ready = 1'b0;
        idle_inputs();
`ifdef IQ_DEMOD_THRESHOLD_EN
        thr_in = '0;
`endif
        test_reset();
        test_basic();
        test_quadrants();
        test_gaps_hold();
        test_len_zero();
        test_reset_abort();
`ifdef IQ_DEMOD_THRESHOLD_EN
        test_threshold();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
